// File: rtl/ins_issue_sched.sv
// Instruction issue scheduler: round-robin arbitration of two instruction streams onto the
// chain, with a credit limit on in-flight slice ops and local execution of FENCE.
module ins_issue_sched #(
  parameter int unsigned INS_W     = 64,
  parameter logic [7:0]  OPC_SLICE = 8'h05,
  parameter logic [7:0]  OPC_FENCE = 8'h0F,
  parameter int unsigned MAX_OUT   = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [INS_W-1:0] req0_ins,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [INS_W-1:0] req1_ins,
  input  logic             req1_valid,
  output logic             req1_ready,
  output logic [INS_W-1:0] out_ins,
  output logic             out_ins_valid,
  input  logic             slice_done,
  output logic [CNT_W-1:0] outstanding,
  output logic             fence_active,
  output logic             err_underflow
);

  typedef enum logic [0:0] {StRun, StFenceWait} state_e;

  localparam logic [CNT_W-1:0] MaxOut = CNT_W'(MAX_OUT);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [INS_W-1:0] out_ins_q, out_ins_d;
  logic             out_vld_q, out_vld_d;

  logic             credit_ok;
  logic             elig0, elig1;
  logic             grant0, grant1;
  logic             accept;
  logic [INS_W-1:0] acc_ins;
  logic             acc_slice, acc_fence;

  // A credit-blocked slice op only makes its own requester ineligible, so the other proceeds.
  always_comb begin
    credit_ok = cnt_q < MaxOut;
    elig0     = (state_q == StRun) && req0_valid &&
                ((req0_ins[7:0] != OPC_SLICE) || credit_ok);
    elig1     = (state_q == StRun) && req1_valid &&
                ((req1_ins[7:0] != OPC_SLICE) || credit_ok);
    // last_grant_q == 1 means req1 won last, so req0 has priority on a tie.
    grant0    = elig0 && (!elig1 || last_grant_q);
    grant1    = elig1 && (!elig0 || !last_grant_q);
    accept    = grant0 || grant1;
    acc_ins   = grant0 ? req0_ins : req1_ins;
    acc_slice = accept && (acc_ins[7:0] == OPC_SLICE);
    acc_fence = accept && (acc_ins[7:0] == OPC_FENCE);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    last_grant_d = last_grant_q;
    if (accept) begin
      last_grant_d = grant1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (acc_fence) begin
          state_d = StFenceWait;
        end
      end
      StFenceWait: begin
        if (cnt_q == '0) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Increment and decrement in the same cycle cancel; a done with nothing in flight is an error.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (acc_slice && !slice_done) begin
      cnt_d = cnt_q + 1'b1;
    end else if (slice_done && !acc_slice) begin
      if (cnt_q == '0) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Fences are consumed here; idle cycles drive a zero word.
  always_comb begin
    out_ins_d = '0;
    out_vld_d = 1'b0;
    if (accept && !acc_fence) begin
      out_ins_d = acc_ins;
      out_vld_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= StRun;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      out_ins_q    <= '0;
      out_vld_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      out_ins_q    <= out_ins_d;
      out_vld_q    <= out_vld_d;
    end
  end

  assign out_ins       = out_ins_q;
  assign out_ins_valid = out_vld_q;
  assign outstanding   = cnt_q;
  assign fence_active  = (state_q == StFenceWait);
  assign err_underflow = err_q;

endmodule

// File: tb/tb_ins_issue_sched.sv
// Directed bench for ins_issue_sched: inputs change on the falling edge, outputs are checked
// 1 ns after that, so each check sees the state left by the preceding rising edge.
module tb_ins_issue_sched;

  localparam logic [7:0] OpSlice = 8'h05;
  localparam logic [7:0] OpFence = 8'h0F;

  logic        sys_clk;
  logic        sys_rst_n;
  logic [63:0] req0_ins;
  logic        req0_valid;
  logic        req0_ready;
  logic [63:0] req1_ins;
  logic        req1_valid;
  logic        req1_ready;
  logic [63:0] out_ins;
  logic        out_ins_valid;
  logic        slice_done;
  logic [2:0]  outstanding;
  logic        fence_active;
  logic        err_underflow;

  int n_cmp;
  int n_err;

  ins_issue_sched dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .req0_ins     (req0_ins),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req1_ins     (req1_ins),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .out_ins      (out_ins),
    .out_ins_valid(out_ins_valid),
    .slice_done   (slice_done),
    .outstanding  (outstanding),
    .fence_active (fence_active),
    .err_underflow(err_underflow)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic logic [63:0] mk(input logic [7:0] tag, input logic [7:0] opc);
    return {48'h0, tag, opc};
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp_word;
    int a;
    int b;
    int n;
    n_cmp      = 0;
    n_err      = 0;
    sys_rst_n  = 1'b0;
    req0_ins   = '0;
    req0_valid = 1'b0;
    req1_ins   = '0;
    req1_valid = 1'b0;
    slice_done = 1'b0;

    // Reset state
    #2;
    check_val("rst_out_vld", 64'(out_ins_valid), 64'd0);
    check_val("rst_out_ins", out_ins, 64'd0);
    check_val("rst_outst", 64'(outstanding), 64'd0);
    check_val("rst_fence", 64'(fence_active), 64'd0);
    check_val("rst_err", 64'(err_underflow), 64'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Round-robin, req0 first, 1-cycle latency
    a = 0;
    b = 0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req0_ins = mk(8'(8'hA0 + a), 8'h01);
      req1_ins = mk(8'(8'hB0 + b), 8'h01);
      #1;
      exp_word = (k % 2 == 0) ? req0_ins : req1_ins;
      check_val("rr_rdy0", 64'(req0_ready), 64'(k % 2 == 0));
      check_val("rr_rdy1", 64'(req1_ready), 64'(k % 2 == 1));
      @(negedge sys_clk);
      check_val("rr_out", out_ins, exp_word);
      check_val("rr_vld", 64'(out_ins_valid), 64'd1);
      if (k % 2 == 0) a++;
      else b++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge sys_clk);
    check_val("idle_vld", 64'(out_ins_valid), 64'd0);
    check_val("idle_ins", out_ins, 64'd0);

    // Credit limit: 4 slice ops accepted, then blocked
    n = 0;
    req0_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      req0_ins = mk(8'(8'h10 + n), OpSlice);
      #1;
      check_val("cred_rdy", 64'(req0_ready), 64'(k < 4));
      @(negedge sys_clk);
      if (k < 4) n++;
    end
    check_val("cred_outst4", 64'(outstanding), 64'd4);
    #1;
    check_val("cred_blk", 64'(req0_ready), 64'd0);
    slice_done = 1'b1;
    #1;
    check_val("cred_blk_done", 64'(req0_ready), 64'd0);
    @(negedge sys_clk);
    slice_done = 1'b0;
    check_val("cred_outst3", 64'(outstanding), 64'd3);
    #1;
    check_val("cred_rdy5", 64'(req0_ready), 64'd1);
    @(negedge sys_clk);
    check_val("cred_out5", out_ins, mk(8'h14, OpSlice));
    check_val("cred_outst4b", 64'(outstanding), 64'd4);

    // Bypass: req0 held on a blocked slice op, req1 flows
    req0_ins   = mk(8'h15, OpSlice);
    req1_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req1_ins = mk(8'(8'hC0 + k), 8'h02);
      #1;
      check_val("byp_rdy0", 64'(req0_ready), 64'd0);
      check_val("byp_rdy1", 64'(req1_ready), 64'd1);
      @(negedge sys_clk);
      check_val("byp_out", out_ins, mk(8'(8'hC0 + k), 8'h02));
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    slice_done = 1'b1;
    @(negedge sys_clk);
    @(negedge sys_clk);
    slice_done = 1'b0;
    check_val("drain_outst2", 64'(outstanding), 64'd2);

    // Fence with 2 outstanding, dones at +3 and +6
    req0_valid = 1'b1;
    req0_ins   = mk(8'hF0, OpFence);
    #1;
    check_val("fen_rdy", 64'(req0_ready), 64'd1);
    for (int c = 1; c <= 8; c++) begin
      @(negedge sys_clk);
      req0_ins   = mk(8'hD0, 8'h02);
      slice_done = (c == 3) || (c == 6);
      #1;
      check_val("fen_active", 64'(fence_active), 64'(c <= 7));
      check_val("fen_rdy0", 64'(req0_ready), 64'(c == 8));
      check_val("fen_outst", 64'(outstanding), (c <= 3) ? 64'd2 : (c <= 6) ? 64'd1 : 64'd0);
      check_val("fen_no_out", 64'(out_ins_valid), 64'd0);
    end
    @(negedge sys_clk);
    slice_done = 1'b0;
    req0_valid = 1'b0;
    check_val("fen_after_out", out_ins, mk(8'hD0, 8'h02));
    check_val("fen_after_vld", 64'(out_ins_valid), 64'd1);

    // Simultaneous accept + done, then underflow
    req0_valid = 1'b1;
    req0_ins   = mk(8'h20, OpSlice);
    @(negedge sys_clk);
    req0_ins   = mk(8'h21, OpSlice);
    @(negedge sys_clk);
    check_val("sim_outst2", 64'(outstanding), 64'd2);
    req0_ins   = mk(8'h22, OpSlice);
    slice_done = 1'b1;
    #1;
    check_val("sim_rdy", 64'(req0_ready), 64'd1);
    @(negedge sys_clk);
    req0_valid = 1'b0;
    check_val("sim_outst_same", 64'(outstanding), 64'd2);
    check_val("sim_out", out_ins, mk(8'h22, OpSlice));
    @(negedge sys_clk);
    check_val("sim_outst1", 64'(outstanding), 64'd1);
    @(negedge sys_clk);
    check_val("sim_outst0", 64'(outstanding), 64'd0);
    check_val("sim_err0", 64'(err_underflow), 64'd0);
    @(negedge sys_clk);
    slice_done = 1'b0;
    check_val("unf_err", 64'(err_underflow), 64'd1);
    check_val("unf_outst", 64'(outstanding), 64'd0);
    @(negedge sys_clk);
    check_val("unf_sticky", 64'(err_underflow), 64'd1);

    // Async reset mid FENCE_WAIT with 3 outstanding
    req0_valid = 1'b1;
    req0_ins   = mk(8'h30, OpSlice);
    @(negedge sys_clk);
    req0_ins   = mk(8'h31, OpSlice);
    @(negedge sys_clk);
    req0_ins   = mk(8'h32, OpSlice);
    @(negedge sys_clk);
    req0_ins   = mk(8'hF1, OpFence);
    @(negedge sys_clk);
    req0_valid = 1'b0;
    check_val("ar_pre_fence", 64'(fence_active), 64'd1);
    check_val("ar_pre_outst", 64'(outstanding), 64'd3);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_val("ar_fence", 64'(fence_active), 64'd0);
    check_val("ar_outst", 64'(outstanding), 64'd0);
    check_val("ar_err", 64'(err_underflow), 64'd0);
    check_val("ar_vld", 64'(out_ins_valid), 64'd0);
    check_val("ar_ins", out_ins, 64'd0);
    @(negedge sys_clk);
    sys_rst_n  = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_ins   = mk(8'h40, 8'h01);
    req1_ins   = mk(8'h50, 8'h01);
    #1;
    check_val("ar_rdy0", 64'(req0_ready), 64'd1);
    check_val("ar_rdy1", 64'(req1_ready), 64'd0);
    @(negedge sys_clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_val("ar_first_out", out_ins, mk(8'h40, 8'h01));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
